// File: rtl/bcd_to_binary_serial.sv
// Serial packed-BCD to unsigned binary converter (reverse double-dabble, one bit per clock).
// Optional `define BCD_SIGN_EN adds sign_in and a two's-complement bin_out one bit wider.
module bcd_to_binary_serial #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
`ifdef BCD_SIGN_EN
    input  logic                  sign_in,
    output logic [BIN_W:0]        bin_out,
`else
    output logic [BIN_W-1:0]      bin_out,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]         state;
    logic [BCD_W-1:0]   bcd_r;
    logic [BIN_W-1:0]   bin_r;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;
`ifdef BCD_SIGN_EN
    logic               sign_r;
    logic signed [BIN_W:0] mag_s;
    logic signed [BIN_W:0] res_s;
`endif

    function automatic logic any_digit_invalid(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Undo the binary-to-BCD "+3 when >= 5" step after each right shift.
    function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (d >= 4'd8) r[4*i +: 4] = d - 4'd3;
        end
        return r;
    endfunction

    assign shifted  = {1'b0, bcd_r, bin_r[BIN_W-1:1]};
    assign bcd_next = correct_digits(shifted[BCD_W+BIN_W-1:BIN_W]);
    assign bin_next = {bcd_r[0], bin_r[BIN_W-1:1]};

`ifdef BCD_SIGN_EN
    assign mag_s = signed'({1'b0, bin_next});
    assign res_s = sign_r ? -mag_s : mag_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            bcd_r   <= '0;
            bin_r   <= '0;
            cnt     <= '0;
            bin_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef BCD_SIGN_EN
            sign_r  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (any_digit_invalid(bcd_in)) begin
                            bin_out <= '0;
                            err     <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            bcd_r  <= bcd_in;
                            bin_r  <= '0;
                            cnt    <= '0;
                            err    <= 1'b0;
                            busy   <= 1'b1;
                            state  <= S_SHIFT;
`ifdef BCD_SIGN_EN
                            sign_r <= sign_in;
`endif
                        end
                    end
                end
                S_SHIFT: begin
                    bcd_r <= bcd_next;
                    bin_r <= bin_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
`ifdef BCD_SIGN_EN
                        bin_out <= res_s;
`else
                        bin_out <= bin_next;
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
